// File: rtl/load_completion_tracker_if.sv
// Load issue / memory response / writeback handshake bundle for load_completion_tracker.
// master is the pipeline side that issues loads and returns data; slave is the tracker.
interface load_completion_tracker_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 5
);
   logic             issue_valid;
   logic             issue_ready;
   logic [DEPTH-1:0] issue_rd;
   logic [WIDTH-1:0] issue_addr;

   logic             mem_resp_valid;
   logic             mem_resp_ready;
   logic [WIDTH-1:0] mem_resp_data;

   logic             wb_valid;
   logic [DEPTH-1:0] wb_rd;
   logic [WIDTH-1:0] wb_data;

   modport master (
      output issue_valid, issue_rd, issue_addr, mem_resp_valid, mem_resp_data,
      input  issue_ready, mem_resp_ready, wb_valid, wb_rd, wb_data
   );

   modport slave (
      input  issue_valid, issue_rd, issue_addr, mem_resp_valid, mem_resp_data,
      output issue_ready, mem_resp_ready, wb_valid, wb_rd, wb_data
   );
endinterface

// File: rtl/load_completion_tracker.sv
// Tracks outstanding loads in order and owns the loading-table write port; table writes and
// writeback appear one cycle after the handshake. Responses outrank issues; flush stalls both.
module load_completion_tracker #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 5,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   load_completion_tracker_if.slave      bus,
   input  logic                          flush,
   output logic                          table_write_enable,
   output logic [DEPTH-1:0]              table_write_index,
   output logic [WIDTH-1:0]              table_write_data,
   output logic [$clog2(QUEUE_DEPTH):0]  outstanding_count,
   output logic                          busy
);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [0:0] ST_ACTIVE = 1'b0;
   localparam logic [0:0] ST_FLUSH  = 1'b1;

   logic [0:0]       state;
   logic [DEPTH-1:0] q [QUEUE_DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [CW-1:0]    count;

   logic             empty;
   logic             full;
   logic             active;
   logic             issue_fire;
   logic             resp_fire;
   logic             pop;
   logic             head_dup;
   logic [PW-1:0]    offset;
   logic [DEPTH-1:0] head_rd;

   logic             wb_valid_q;
   logic [DEPTH-1:0] wb_rd_q;
   logic [WIDTH-1:0] wb_data_q;

   assign empty   = (count == '0);
   assign full    = (count == CW'(QUEUE_DEPTH));
   assign active  = (state == ST_ACTIVE);
   assign head_rd = q[head];

   assign bus.mem_resp_ready = active && !flush && !empty;
   assign bus.issue_ready    = active && !flush && !full && !(bus.mem_resp_valid && !empty);

   assign issue_fire = bus.issue_valid && bus.issue_ready;
   assign resp_fire  = bus.mem_resp_valid && bus.mem_resp_ready;
   assign pop        = resp_fire || (state == ST_FLUSH);

   // A younger queued load to the same rd still owns the table entry, so the head must not clear it.
   always_comb begin
      head_dup = 1'b0;
      offset   = '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         offset = PW'(i) - head;
         if (offset != '0 && {1'b0, offset} < count && q[i] == head_rd)
            head_dup = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= ST_ACTIVE;
         head               <= '0;
         tail               <= '0;
         count              <= '0;
         wb_valid_q         <= 1'b0;
         wb_rd_q            <= '0;
         wb_data_q          <= '0;
         table_write_enable <= 1'b0;
         table_write_index  <= '0;
         table_write_data   <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++)
            q[i] <= '0;
      end else begin
         wb_valid_q         <= 1'b0;
         table_write_enable <= 1'b0;

         if (issue_fire) begin
            q[tail] <= bus.issue_rd;
            tail    <= tail + 1'b1;
            if (bus.issue_rd != '0) begin
               table_write_enable <= 1'b1;
               table_write_index  <= bus.issue_rd;
               table_write_data   <= bus.issue_addr | WIDTH'(1);
            end
         end

         if (pop) begin
            head <= head + 1'b1;
            if (resp_fire) begin
               wb_valid_q <= 1'b1;
               wb_rd_q    <= head_rd;
               wb_data_q  <= bus.mem_resp_data;
            end
            if (!head_dup && head_rd != '0) begin
               table_write_enable <= 1'b1;
               table_write_index  <= head_rd;
               table_write_data   <= '0;
            end
         end

         if (issue_fire && !pop)
            count <= count + 1'b1;
         else if (pop && !issue_fire)
            count <= count - 1'b1;

         case (state)
            ST_ACTIVE: if (flush && !empty) state <= ST_FLUSH;
            ST_FLUSH:  if (count == CW'(1)) state <= ST_ACTIVE;
            default:   state <= ST_ACTIVE;
         endcase
      end
   end

   assign bus.wb_valid       = wb_valid_q;
   assign bus.wb_rd          = wb_rd_q;
   assign bus.wb_data        = wb_data_q;
   assign outstanding_count  = count;
   assign busy               = (state == ST_FLUSH);
endmodule

// File: tb/tb_load_completion_tracker.sv
// Scenario bench for load_completion_tracker: expected writebacks and table writes are queued
// as stimulus is driven and matched against the DUT strobes by a negedge monitor.
module tb_load_completion_tracker;
   typedef struct packed { logic [4:0] idx; logic [31:0] data; } tw_t;
   typedef struct packed { logic [4:0] rd;  logic [31:0] data; } wb_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        table_write_enable;
   logic [4:0]  table_write_index;
   logic [31:0] table_write_data;
   logic [2:0]  outstanding_count;
   logic        busy;

   int checks = 0;
   int failures = 0;

   tw_t        exp_tw[$];
   wb_t        exp_wb[$];
   logic [4:0] mdl[$];
   tw_t        got_tw, want_tw;
   wb_t        got_wb, want_wb;

   load_completion_tracker_if #(.WIDTH(32), .DEPTH(5)) bus ();

   load_completion_tracker #(.WIDTH(32), .DEPTH(5), .QUEUE_DEPTH(4)) dut (
      .clk                (clk),
      .reset              (reset),
      .bus                (bus),
      .flush              (flush),
      .table_write_enable (table_write_enable),
      .table_write_index  (table_write_index),
      .table_write_data   (table_write_data),
      .outstanding_count  (outstanding_count),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (table_write_enable) begin
            checks++;
            got_tw = '{table_write_index, table_write_data};
            if (exp_tw.size() == 0) begin
               failures++;
               $display("FAIL table_write unexpected: idx=%0d data=%h, required no write", got_tw.idx, got_tw.data);
            end else begin
               want_tw = exp_tw.pop_front();
               if (got_tw !== want_tw) begin
                  failures++;
                  $display("FAIL table_write: idx=%0d data=%h, required idx=%0d data=%h",
                           got_tw.idx, got_tw.data, want_tw.idx, want_tw.data);
               end
            end
         end
         if (bus.wb_valid) begin
            checks++;
            got_wb = '{bus.wb_rd, bus.wb_data};
            if (exp_wb.size() == 0) begin
               failures++;
               $display("FAIL writeback unexpected: rd=%0d data=%h, required no writeback", got_wb.rd, got_wb.data);
            end else begin
               want_wb = exp_wb.pop_front();
               if (got_wb !== want_wb) begin
                  failures++;
                  $display("FAIL writeback: rd=%0d data=%h, required rd=%0d data=%h",
                           got_wb.rd, got_wb.data, want_wb.rd, want_wb.data);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit in_mdl(input logic [4:0] r);
      foreach (mdl[i]) if (mdl[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   // Model of a head pop: clear the table entry unless a younger load still targets it.
   task automatic model_pop(output logic [4:0] h);
      h = mdl.pop_front();
      if (h != 5'd0 && !in_mdl(h)) exp_tw.push_back('{h, 32'h0});
   endtask

   task automatic do_issue(input logic [4:0] rd, input logic [31:0] addr);
      int n = 0;
      bit ok;
      bus.issue_valid = 1'b1;
      bus.issue_rd    = rd;
      bus.issue_addr  = addr;
      @(negedge clk);
      while (!bus.issue_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = bus.issue_ready;
      checks++;
      if (bus.issue_ready !== 1'b1) begin
         failures++;
         $display("FAIL issue_accept rd=%0d: issue_ready=%b, required 1", rd, bus.issue_ready);
      end
      @(posedge clk);
      #1;
      bus.issue_valid = 1'b0;
      if (ok) begin
         mdl.push_back(rd);
         if (rd != 5'd0) exp_tw.push_back('{rd, addr | 32'h1});
      end
   endtask

   task automatic do_resp(input logic [31:0] data);
      int n = 0;
      bit ok;
      logic [4:0] h;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = data;
      @(negedge clk);
      while (!bus.mem_resp_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = bus.mem_resp_ready;
      checks++;
      if (bus.mem_resp_ready !== 1'b1) begin
         failures++;
         $display("FAIL resp_accept data=%h: mem_resp_ready=%b, required 1", data, bus.mem_resp_ready);
      end
      @(posedge clk);
      #1;
      bus.mem_resp_valid = 1'b0;
      if (ok && mdl.size() > 0) begin
         model_pop(h);
         exp_wb.push_back('{h, data});
      end
   endtask

   task automatic test_reset;
      bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_addr = '0;
      bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.wb_valid, bus.wb_rd, bus.wb_data, table_write_enable, table_write_index,
           table_write_data, outstanding_count, busy, bus.mem_resp_ready} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: wb=%b/%0d/%h tw=%b/%0d/%h cnt=%0d busy=%b rresp=%b, required all 0",
                  bus.wb_valid, bus.wb_rd, bus.wb_data, table_write_enable, table_write_index,
                  table_write_data, outstanding_count, busy, bus.mem_resp_ready);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.issue_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_issue_ready: %b, required 1", bus.issue_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single;
      do_issue(5'd5, 32'h0000_1000);
      @(negedge clk);
      checks++;
      if (outstanding_count !== 3'd1) begin
         failures++;
         $display("FAIL single_count_after_issue: %0d, required 1", outstanding_count);
      end
      @(posedge clk); #1;
      do_resp(32'hDEAD_BEEF);
      @(negedge clk);
      checks++;
      if (outstanding_count !== 3'd0) begin
         failures++;
         $display("FAIL single_count_after_resp: %0d, required 0", outstanding_count);
      end
      repeat (2) @(posedge clk); #1;
      checks++;
      if (exp_tw.size() + exp_wb.size() !== 0) begin
         failures++;
         $display("FAIL single_drain: %0d expected events missing, required 0", exp_tw.size() + exp_wb.size());
      end
   endtask

   task automatic test_back_to_back;
      for (int r = 1; r <= 4; r++) do_issue(5'(r), 32'h2000 + 32'(r * 16));
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.issue_addr = 32'h5000;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({bus.issue_ready, outstanding_count} !== {1'b0, 3'd4}) begin
            failures++;
            $display("FAIL full_hold cycle %0d: ready=%b count=%0d, required ready=0 count=4",
                     c, bus.issue_ready, outstanding_count);
         end
      end
      @(posedge clk); #1;
      bus.issue_valid = 1'b0;
      for (int r = 1; r <= 4; r++) do_resp(32'hC0DE_0000 + 32'(r));
      for (int r = 8; r <= 10; r++) do_issue(5'(r), 32'h3000 + 32'(r));
      do_resp(32'hAAAA_0008);
      do_resp(32'hAAAA_0009);
      do_issue(5'd11, 32'h3100);
      do_issue(5'd12, 32'h3200);
      for (int r = 10; r <= 12; r++) do_resp(32'hAAAA_0000 + 32'(r));
      @(negedge clk);
      checks++;
      if (outstanding_count !== 3'd0) begin
         failures++;
         $display("FAIL b2b_final_count: %0d, required 0", outstanding_count);
      end
      repeat (2) @(posedge clk); #1;
      checks++;
      if (exp_tw.size() + exp_wb.size() !== 0) begin
         failures++;
         $display("FAIL b2b_drain: %0d expected events missing, required 0", exp_tw.size() + exp_wb.size());
      end
   endtask

   task automatic test_duplicate_rd;
      do_issue(5'd7, 32'h0000_7000);
      do_issue(5'd7, 32'h0000_7100);
      do_resp(32'h1111_1111);
      do_resp(32'h2222_2222);
      repeat (3) @(posedge clk); #1;
      checks++;
      if (exp_tw.size() + exp_wb.size() !== 0) begin
         failures++;
         $display("FAIL dup_drain: %0d expected events missing, required 0", exp_tw.size() + exp_wb.size());
      end
   endtask

   task automatic test_collision;
      logic [4:0] h;
      do_issue(5'd20, 32'h0000_1400);
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.issue_addr = 32'h0000_0900;
      bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h55AA_55AA;
      @(negedge clk);
      checks++;
      if ({bus.issue_ready, bus.mem_resp_ready} !== 2'b01) begin
         failures++;
         $display("FAIL collision_arb: issue_ready=%b mem_resp_ready=%b, required 0 and 1",
                  bus.issue_ready, bus.mem_resp_ready);
      end
      @(posedge clk); #1;
      model_pop(h);
      exp_wb.push_back('{h, 32'h55AA_55AA});
      bus.mem_resp_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.issue_ready !== 1'b1) begin
         failures++;
         $display("FAIL collision_issue_next: issue_ready=%b, required 1", bus.issue_ready);
      end
      @(posedge clk); #1;
      bus.issue_valid = 1'b0;
      mdl.push_back(5'd9);
      exp_tw.push_back('{5'd9, 32'h0000_0901});
      @(negedge clk);
      checks++;
      if (outstanding_count !== 3'd1) begin
         failures++;
         $display("FAIL collision_count: %0d, required 1", outstanding_count);
      end
      @(posedge clk); #1;
      do_resp(32'h9999_9999);
      repeat (2) @(posedge clk); #1;
      checks++;
      if (exp_tw.size() + exp_wb.size() !== 0) begin
         failures++;
         $display("FAIL collision_drain: %0d expected events missing, required 0", exp_tw.size() + exp_wb.size());
      end
   endtask

   task automatic test_flush;
      int busy_n = 0;
      int n = 0;
      logic [4:0] h;
      do_issue(5'd3, 32'h0000_0300);
      do_issue(5'd6, 32'h0000_0600);
      do_issue(5'd0, 32'h0000_0000);
      flush = 1'b1;
      @(posedge clk); #1;
      while (mdl.size() > 0) model_pop(h);
      @(negedge clk);
      checks++;
      if ({busy, bus.issue_ready, bus.mem_resp_ready} !== 3'b100) begin
         failures++;
         $display("FAIL flush_enter: busy=%b issue_ready=%b mem_resp_ready=%b, required 1 0 0",
                  busy, bus.issue_ready, bus.mem_resp_ready);
      end
      while (busy && n < 20) begin
         busy_n++;
         @(negedge clk);
         n++;
      end
      flush = 1'b0;
      checks++;
      if (busy_n !== 3) begin
         failures++;
         $display("FAIL flush_busy_cycles: %0d, required 3", busy_n);
      end
      checks++;
      if ({busy, outstanding_count} !== 4'b0000) begin
         failures++;
         $display("FAIL flush_exit: busy=%b count=%0d, required 0 0", busy, outstanding_count);
      end
      repeat (2) @(posedge clk); #1;
      checks++;
      if (exp_tw.size() + exp_wb.size() !== 0) begin
         failures++;
         $display("FAIL flush_drain: %0d expected events missing, required 0", exp_tw.size() + exp_wb.size());
      end
   endtask

   task automatic test_rd_zero_and_empty_resp;
      bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hBAD0_BAD0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if ({bus.mem_resp_ready, outstanding_count} !== 4'b0000) begin
            failures++;
            $display("FAIL empty_resp cycle %0d: ready=%b count=%0d, required 0 0",
                     c, bus.mem_resp_ready, outstanding_count);
         end
      end
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
      do_issue(5'd0, 32'h0000_0040);
      do_resp(32'h1234_5678);
      repeat (3) @(posedge clk); #1;
      checks++;
      if (exp_tw.size() + exp_wb.size() !== 0) begin
         failures++;
         $display("FAIL rd0_drain: %0d expected events missing, required 0", exp_tw.size() + exp_wb.size());
      end
   endtask

   task automatic test_reset_in_flush;
      do_issue(5'd10, 32'h0000_0A00);
      do_issue(5'd11, 32'h0000_0B00);
      do_issue(5'd12, 32'h0000_0C00);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      mdl.delete();
      exp_tw.delete();
      exp_wb.delete();
      @(negedge clk);
      checks++;
      if ({bus.wb_valid, bus.wb_rd, bus.wb_data, table_write_enable, table_write_index,
           table_write_data, outstanding_count, busy} !== '0) begin
         failures++;
         $display("FAIL reset_in_flush: wb=%b tw=%b/%0d/%h cnt=%0d busy=%b, required all 0",
                  bus.wb_valid, table_write_enable, table_write_index, table_write_data,
                  outstanding_count, busy);
      end
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.issue_ready, busy, outstanding_count} !== 5'b10000) begin
         failures++;
         $display("FAIL after_reset_in_flush: ready=%b busy=%b count=%0d, required 1 0 0",
                  bus.issue_ready, busy, outstanding_count);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_duplicate_rd();
      test_collision();
      test_flush();
      test_rd_zero_and_empty_resp();
      test_reset_in_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
